// File: rtl/risc_v_processor.sv
// Single-cycle RV64 subset processor (add, sub, and, or, addi, ld, sd, beq).
// Ports:
//   clk          - single clock, all state updates on the rising edge
//   reset        - asynchronous, active-low; clears PC, register file and data memory
//   PC_Out       - current instruction address;  PC_In - next PC
//   Instruction  - word fetched at PC_Out from the 16-word program ROM
//   ReadData1/2  - register reads of rs1/rs2;    imm_data - sign-extended immediate
//   Mux2Out      - ALU B operand;  Result - ALU result / data address;  ZERO - Result==0
//   Read_Data    - data-memory read;  WriteData - register write-back value
//   Adder1Out    - PC_Out+4;  Adder2Out - branch target
//   Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp - main control
//   Operation    - ALU control code
//   val1..val4   - data-memory doublewords at byte addresses 0, 8, 16, 24
module risc_v_processor (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] PC_Out,
    output logic [63:0] PC_In,
    output logic [31:0] Instruction,
    output logic [63:0] ReadData1,
    output logic [63:0] ReadData2,
    output logic [63:0] imm_data,
    output logic [63:0] Mux2Out,
    output logic [63:0] Result,
    output logic        ZERO,
    output logic [63:0] Read_Data,
    output logic [63:0] WriteData,
    output logic [63:0] Adder1Out,
    output logic [63:0] Adder2Out,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemtoReg,
    output logic        MemWrite,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic [1:0]  ALUOp,
    output logic [3:0]  Operation,
    output logic [63:0] val1,
    output logic [63:0] val2,
    output logic [63:0] val3,
    output logic [63:0] val4
);

    localparam int unsigned XLEN      = 64;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned NUM_DWORD = 8;   // 64 bytes of data memory

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] regs [NUM_REGS];
    logic [XLEN-1:0] dmem [NUM_DWORD];

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    ctrl_t      ctrl;

    assign PC_Out = pc_q;
    assign opcode = Instruction[6:0];
    assign funct3 = Instruction[14:12];
    assign rd     = Instruction[11:7];
    assign rs1    = Instruction[19:15];
    assign rs2    = Instruction[24:20];

    // Program ROM; PC wraps through the 4-bit word index only.
    always_comb begin
        Instruction = 32'h0000_0000;
        case (PC_Out[5:2])
            4'd0:    Instruction = 32'h0050_0093; // addi x1,x0,5
            4'd1:    Instruction = 32'h0030_0113; // addi x2,x0,3
            4'd2:    Instruction = 32'h0020_81B3; // add  x3,x1,x2
            4'd3:    Instruction = 32'h4020_8233; // sub  x4,x1,x2
            4'd4:    Instruction = 32'h0030_3023; // sd   x3,0(x0)
            4'd5:    Instruction = 32'h0040_3423; // sd   x4,8(x0)
            4'd6:    Instruction = 32'h0000_3283; // ld   x5,0(x0)
            4'd7:    Instruction = 32'h0032_8463; // beq  x5,x3,+8
            4'd8:    Instruction = 32'h0010_0313; // addi x6,x0,1
            4'd9:    Instruction = 32'h0020_F3B3; // and  x7,x1,x2
            4'd10:   Instruction = 32'h0020_E433; // or   x8,x1,x2
            4'd11:   Instruction = 32'h0080_3823; // sd   x8,16(x0)
            4'd12:   Instruction = 32'h0000_0063; // beq  x0,x0,0
            default: Instruction = 32'h0000_0000;
        endcase
    end

    // Main control decode; unknown opcodes behave as a NOP.
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_R:    ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
            OP_ADDI: ctrl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
            OP_LD:   ctrl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
            OP_SD:   ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
            OP_BEQ:  ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
            default: ctrl = '0;
        endcase
    end

    assign ALUSrc   = ctrl.alu_src;
    assign MemtoReg = ctrl.mem_to_reg;
    assign RegWrite = ctrl.reg_write;
    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign Branch   = ctrl.branch;
    assign ALUOp    = ctrl.alu_op;

    // Immediate generation; the branch immediate is in half-words.
    always_comb begin
        imm_data = '0;
        case (opcode)
            OP_ADDI, OP_LD: imm_data = {{52{Instruction[31]}}, Instruction[31:20]};
            OP_SD:          imm_data = {{52{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
            OP_BEQ:         imm_data = {{52{Instruction[31]}}, Instruction[31], Instruction[7],
                                        Instruction[30:25], Instruction[11:8]};
            default:        imm_data = '0;
        endcase
    end

    // ALU control.
    always_comb begin
        Operation = ALU_ADD;
        case (ALUOp)
            2'b00: Operation = ALU_ADD;
            2'b01: Operation = ALU_SUB;
            2'b10: begin
                case ({Instruction[30], funct3})
                    4'b0000: Operation = ALU_ADD;
                    4'b1000: Operation = ALU_SUB;
                    4'b0111: Operation = ALU_AND;
                    4'b0110: Operation = ALU_OR;
                    default: Operation = ALU_ADD;
                endcase
            end
            default: Operation = ALU_ADD;
        endcase
    end

    // Register reads; x0 is hard-wired to zero.
    assign ReadData1 = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign ReadData2 = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign Mux2Out   = ALUSrc ? imm_data : ReadData2;

    // ALU.
    always_comb begin
        Result = '0;
        case (Operation)
            ALU_AND: Result = ReadData1 & Mux2Out;
            ALU_OR:  Result = ReadData1 | Mux2Out;
            ALU_ADD: Result = ReadData1 + Mux2Out;
            ALU_SUB: Result = ReadData1 - Mux2Out;
            default: Result = '0;
        endcase
    end

    assign ZERO = (Result == '0);

    // Data memory holds only aligned doublewords, so byte order is implicit.
    assign Read_Data = MemRead ? dmem[Result[5:3]] : '0;
    assign WriteData = MemtoReg ? Read_Data : Result;
    assign val1      = dmem[0];
    assign val2      = dmem[1];
    assign val3      = dmem[2];
    assign val4      = dmem[3];

    // Next-PC selection.
    assign Adder1Out = PC_Out + 64'd4;
    assign Adder2Out = PC_Out + (imm_data << 1);
    assign PC_In     = (Branch && ZERO) ? Adder2Out : Adder1Out;

    // Program counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= PC_In;
        end
    end

    // Register file write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWrite && (rd != 5'd0)) begin
            regs[rd] <= WriteData;
        end
    end

    // Data memory write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DWORD; i++) begin
                dmem[i] <= '0;
            end
        end else if (MemWrite) begin
            dmem[Result[5:3]] <= ReadData2;
        end
    end

endmodule

// File: tb/tb_risc_v_processor.sv
// Directed bench for risc_v_processor: steps the fixed ROM program edge by
// edge and compares datapath, control and state against hand-computed values.
module tb_risc_v_processor;

    logic        clk;
    logic        reset;
    logic [63:0] PC_Out, PC_In;
    logic [31:0] Instruction;
    logic [63:0] ReadData1, ReadData2, imm_data, Mux2Out, Result;
    logic        ZERO;
    logic [63:0] Read_Data, WriteData, Adder1Out, Adder2Out;
    logic        Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [1:0]  ALUOp;
    logic [3:0]  Operation;
    logic [63:0] val1, val2, val3, val4;

    int checks = 0;
    int errors = 0;

    risc_v_processor dut (
        .clk(clk), .reset(reset),
        .PC_Out(PC_Out), .PC_In(PC_In), .Instruction(Instruction),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .imm_data(imm_data),
        .Mux2Out(Mux2Out), .Result(Result), .ZERO(ZERO),
        .Read_Data(Read_Data), .WriteData(WriteData),
        .Adder1Out(Adder1Out), .Adder2Out(Adder2Out),
        .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .ALUOp(ALUOp), .Operation(Operation),
        .val1(val1), .val2(val2), .val3(val3), .val4(val4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One rising edge, then sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        #1;
        check("rst_pc", PC_Out, 64'd0);
        check("rst_val1", val1, 64'd0);
        #9;
        reset = 1'b1;
        #1;
        // PC 0: addi x1,x0,5
        check("pc0_pc", PC_Out, 64'd0);
        check("pc0_instr", {32'd0, Instruction}, 64'h0050_0093);
        check("pc0_add1", Adder1Out, 64'd4);
        check("pc0_alusrc", {63'd0, ALUSrc}, 64'd1);
        check("pc0_regwrite", {63'd0, RegWrite}, 64'd1);
        check("pc0_result", Result, 64'd5);

        step(); // PC 4
        check("x1_after1", dut.regs[1], 64'd5);
        step(); // PC 8: add
        check("pc8_op", {60'd0, Operation}, 64'h2);
        check("pc8_rd1", ReadData1, 64'd5);
        check("pc8_rd2", ReadData2, 64'd3);
        check("pc8_result", Result, 64'd8);
        step(); // PC 12: sub
        check("pc12_op", {60'd0, Operation}, 64'h6);
        check("pc12_result", Result, 64'd2);
        step(); // PC 16: sd x3
        check("e4_pc", PC_Out, 64'd16);
        check("e4_x1", dut.regs[1], 64'd5);
        check("e4_x2", dut.regs[2], 64'd3);
        check("e4_x3", dut.regs[3], 64'd8);
        check("e4_x4", dut.regs[4], 64'd2);
        check("pc16_memwrite", {63'd0, MemWrite}, 64'd1);
        check("pc16_regwrite", {63'd0, RegWrite}, 64'd0);
        check("pc16_rd2", ReadData2, 64'd8);
        step(); // PC 20: sd x4,8
        check("e5_val1", val1, 64'd8);
        check("pc20_imm", imm_data, 64'd8);
        check("pc20_result", Result, 64'd8);
        step(); // PC 24: ld x5
        check("e6_val2", val2, 64'd2);
        check("pc24_memread", {63'd0, MemRead}, 64'd1);
        check("pc24_readdata", Read_Data, 64'd8);
        check("pc24_writedata", WriteData, 64'd8);

        // Asynchronous reset pulse between edges.
        #2;
        reset = 1'b0;
        #1;
        check("arst_pc", PC_Out, 64'd0);
        check("arst_val1", val1, 64'd0);
        check("arst_val2", val2, 64'd0);
        check("arst_x3", dut.regs[3], 64'd0);
        check("arst_instr", {32'd0, Instruction}, 64'h0050_0093);
        #1;
        reset = 1'b1;

        step(); // first post-release edge runs address 0
        check("rr_pc", PC_Out, 64'd4);
        check("rr_x1", dut.regs[1], 64'd5);
        step(); step(); step(); step(); step(); step(); // PC 28: beq x5,x3,+8
        check("pc28_pc", PC_Out, 64'd28);
        check("pc28_zero", {63'd0, ZERO}, 64'd1);
        check("pc28_branch", {63'd0, Branch}, 64'd1);
        check("pc28_imm", imm_data, 64'd4);
        check("pc28_add2", Adder2Out, 64'd36);
        check("pc28_pcin", PC_In, 64'd36);
        step(); // PC 36: and x7
        check("pc36_pc", PC_Out, 64'd36);
        check("pc36_x5", dut.regs[5], 64'd8);
        check("pc36_x6", dut.regs[6], 64'd0);
        check("pc36_op", {60'd0, Operation}, 64'h0);
        check("pc36_wdata", WriteData, 64'd1);
        step(); // PC 40: or x8
        check("pc40_op", {60'd0, Operation}, 64'h1);
        check("pc40_wdata", WriteData, 64'd7);
        step(); // PC 44: sd x8,16
        check("pc44_x7", dut.regs[7], 64'd1);
        step(); // PC 48: beq x0,x0,0
        check("pc48_pc", PC_Out, 64'd48);
        check("pc48_x8", dut.regs[8], 64'd7);
        step(); // 12th edge: holds at 48
        check("e12_pc", PC_Out, 64'd48);
        check("e12_pcin", PC_In, 64'd48);
        check("e12_add1", Adder1Out, 64'd52);
        check("e12_val1", val1, 64'd8);
        check("e12_val2", val2, 64'd2);
        check("e12_val3", val3, 64'd7);
        check("e12_val4", val4, 64'd0);
        check("e12_x5", dut.regs[5], 64'd8);
        check("e12_x6", dut.regs[6], 64'd0);
        check("e12_x7", dut.regs[7], 64'd1);
        check("e12_x8", dut.regs[8], 64'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
